// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands two bits per clock through one 2-bit slice, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a `sub` port selecting A + ~B + 1.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Sum_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d, sub_in;
    logic [1:0]       a_sl, b_sl;
    logic [2:0]       slice;
    logic             last, accept;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        sum_d   = sum_q;
        a_sl    = '0;
        b_sl    = '0;
        for (int i = 0; i < WIDTH/2; i++)
            if (cnt_q == CNT_W'(i)) begin
                a_sl = a_q[2*i +: 2];
                b_sl = b_q[2*i +: 2];
            end
        // subtraction inverts B slice-by-slice; the +1 comes from the preset carry
        slice  = {1'b0, a_sl} + {1'b0, b_sl ^ {2{sub_q}}} + {2'b00, carry_q};
        last   = cnt_q == CNT_W'(WIDTH/2 - 1);
        accept = start && state_q != RUN;
        if (accept) begin
            state_d = RUN;
            a_d     = A;
            b_d     = B;
            sub_d   = sub_in;
            carry_d = sub_in;
            cnt_d   = '0;
            part_d  = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < WIDTH/2; i++)
                if (cnt_q == CNT_W'(i)) part_d[2*i +: 2] = slice[1:0];
            carry_d = slice[2];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                sum_d   = {slice[2], part_d};
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
        end
    end

    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign Sum_out = sum_q;
endmodule
